tx_sched: RTL and testbench

Two-requester frame scheduler in front of the 4-bit nibble serializer (4-bit parallel in, one bit per clk, bit 0 first, 4-clock slot). Accepts bytes from two requesters over valid/ready handshakes and arbitrates round-robin. Wraps each byte in a header nibble and emits low then high nibbles, presenting one nibble per 4-clock slot aligned to the serializer's slot counter. Fills unused slots with an idle nibble.

---
 rtl/tx_sched_pkg.sv | 32 +++
 rtl/tx_sched_rr_arb2.sv | 39 +++
 rtl/tx_sched.sv | 136 +++++++++++++
 tb/tb_tx_sched.sv | 341 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tx_sched_pkg.sv
// -----------------------------------------------------------------------------
// tx_sched_pkg
// Shared definitions for the two-requester frame scheduler:
//   - FSM state encoding (IDLE -> HDR -> LO -> HI)
//   - slot counter boundary value
//   - default idle nibble and header tag
//   - helper that assembles a header nibble from tag and requester id
// -----------------------------------------------------------------------------
package tx_sched_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HDR  = 2'd1,
        ST_LO   = 2'd2,
        ST_HI   = 2'd3
    } state_t;

    // Request / grant vector, bit index = requester id.
    typedef logic [1:0] req_vec_t;

    // Last bit slot of a 4-clock serializer slot period.
    localparam logic [1:0] SLOT_LAST    = 2'd3;

    localparam logic [3:0] DEF_IDLE_NIB = 4'h0;
    localparam logic [2:0] DEF_HDR_TAG  = 3'b110;

    // Header nibble: tag in the upper three bits, requester id in bit 0.
    function automatic logic [3:0] hdr_nib(input logic [2:0] tag, input logic id);
        return {tag, id};
    endfunction

endpackage

// File: rtl/tx_sched_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-way round-robin arbiter, purely combinational. The history bit `last`
// is owned by the caller and updated only when a grant is taken.
//
// Ports:
//   req     in   2  request vector, bit i = requester i valid
//   last    in   1  id of the requester served most recently
//   en      in   1  grant enable; 0 forces gnt to zero
//   gnt     out  2  one-hot grant, or zero when nothing is granted
//   gnt_id  out  1  index of the granted requester (0 when no grant)
// -----------------------------------------------------------------------------
module rr_arb2
    import tx_sched_pkg::*;
(
    input  req_vec_t req,
    input  logic     last,
    input  logic     en,
    output req_vec_t gnt,
    output logic     gnt_id
);

    always_comb begin
        // NOTE: every output gets a default before any branch so no path
        // leaves a value unassigned, which would infer a latch.
        gnt    = 2'b00;
        gnt_id = 1'b0;
        if (en && (req != 2'b00)) begin
            if (req == 2'b11) begin
                // Tie: serve the requester that was not served last.
                gnt_id = ~last;
            end else begin
                gnt_id = req[1];
            end
            gnt = gnt_id ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/tx_sched.sv
// -----------------------------------------------------------------------------
// tx_sched
// Two-requester frame scheduler feeding a 4-bit nibble serializer. Each
// accepted byte is sent as three nibbles, one per 4-clock slot period:
// header {HDR_TAG, id}, data[3:0], data[7:4]. Unused slot periods carry
// IDLE_NIB. All nibble/state changes happen on the edge that ends slot 3,
// so the serializer always loads a new nibble at slot 0.
//
// Ports:
//   clk          in   1  system clock, shared with the serializer
//   rst          in   1  asynchronous active-high reset
//   en           in   1  1 = new grants allowed; 0 = finish frame, then idle
//   req0_valid   in   1  requester 0 has a byte
//   req0_data    in   8  requester 0 byte, held while valid
//   req0_ready   out  1  requester 0 byte accepted this cycle
//   req1_valid   in   1  requester 1 has a byte
//   req1_data    in   8  requester 1 byte, held while valid
//   req1_ready   out  1  requester 1 byte accepted this cycle
//   nib          out  4  nibble to serializer parallel input
//   slot         out  2  current bit slot 0..3
//   frame_start  out  1  pulse in the first slot-0 cycle of a header
//   busy         out  1  frame in flight
// -----------------------------------------------------------------------------
module tx_sched
    import tx_sched_pkg::*;
#(
    parameter logic [3:0] IDLE_NIB = DEF_IDLE_NIB,
    parameter logic [2:0] HDR_TAG  = DEF_HDR_TAG
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       req0_valid,
    input  logic [7:0] req0_data,
    output logic       req0_ready,
    input  logic       req1_valid,
    input  logic [7:0] req1_data,
    output logic       req1_ready,
    output logic [3:0] nib,
    output logic [1:0] slot,
    output logic       frame_start,
    output logic       busy
);

    state_t     state;
    logic       last;
    logic [7:0] data_q;

    logic       boundary;
    logic       grant_point;
    req_vec_t   gnt;
    logic       gnt_id;
    logic       granted;
    logic [7:0] gnt_data;

    // -------------------------------------------------------------------------
    // Slot counter: free running, aligned with the serializer's bit counter.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (rst) begin
            slot <= 2'd0;
        end else begin
            slot <= slot + 2'd1;
        end
    end

    assign boundary    = (slot == SLOT_LAST);
    // A new byte can only be taken where the current frame (if any) ends.
    assign grant_point = boundary && ((state == ST_IDLE) || (state == ST_HI));

    // Gating the arbiter with grant_point keeps ready low everywhere else.
    rr_arb2 u_arb (
        .req    ({req1_valid, req0_valid}),
        .last   (last),
        .en     (en && grant_point),
        .gnt    (gnt),
        .gnt_id (gnt_id)
    );

    assign req0_ready = gnt[0];
    assign req1_ready = gnt[1];
    assign granted    = |gnt;
    assign gnt_data   = gnt_id ? req1_data : req0_data;

    // -------------------------------------------------------------------------
    // Frame FSM with registered nibble and status outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            nib         <= IDLE_NIB;
            last        <= 1'b1;
            frame_start <= 1'b0;
            busy        <= 1'b0;
            data_q      <= 8'h00;
        end else begin
            // frame_start is set only on a grant edge, so it lives for
            // exactly the slot-0 cycle of the header period.
            frame_start <= 1'b0;
            if (boundary) begin
                case (state)
                    ST_IDLE, ST_HI: begin
                        if (granted) begin
                            state       <= ST_HDR;
                            nib         <= hdr_nib(HDR_TAG, gnt_id);
                            data_q      <= gnt_data;
                            last        <= gnt_id;
                            frame_start <= 1'b1;
                            busy        <= 1'b1;
                        end else begin
                            state <= ST_IDLE;
                            nib   <= IDLE_NIB;
                            busy  <= 1'b0;
                        end
                    end
                    ST_HDR: begin
                        state <= ST_LO;
                        nib   <= data_q[3:0];
                    end
                    ST_LO: begin
                        state <= ST_HI;
                        nib   <= data_q[7:4];
                    end
                    default: begin
                        state <= ST_IDLE;
                        nib   <= IDLE_NIB;
                        busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tx_sched.sv
// -----------------------------------------------------------------------------
// tb_tx_sched
// Self-checking bench for tx_sched. A table of single-frame vectors from
// reset, hand-written multi-cycle sequences, and a randomized run compared
// every cycle against a reference model that tracks the outgoing stream as a
// queue of pending slot-period nibbles.
// -----------------------------------------------------------------------------
module tb_tx_sched;

    localparam logic [3:0] IDLE_NIB = 4'h0;
    localparam logic [2:0] HDR_TAG  = 3'b110;

    logic       clk;
    logic       rst;
    logic       en;
    logic       req0_valid;
    logic [7:0] req0_data;
    logic       req0_ready;
    logic       req1_valid;
    logic [7:0] req1_data;
    logic       req1_ready;
    logic [3:0] nib;
    logic [1:0] slot;
    logic       frame_start;
    logic       busy;

    tx_sched #(
        .IDLE_NIB (IDLE_NIB),
        .HDR_TAG  (HDR_TAG)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .en          (en),
        .req0_valid  (req0_valid),
        .req0_data   (req0_data),
        .req0_ready  (req0_ready),
        .req1_valid  (req1_valid),
        .req1_data   (req1_data),
        .req1_ready  (req1_ready),
        .nib         (nib),
        .slot        (slot),
        .frame_start (frame_start),
        .busy        (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------------------------------------------------------------
    // Reference model: stream of slot-period nibbles. A grant appends three
    // nibbles; each boundary moves the next queued nibble onto the output.
    // ---------------------------------------------------------------------
    int         m_slot;
    logic [3:0] m_nib;
    logic       m_busy;
    logic       m_fs;
    logic       m_last;
    logic [3:0] m_q[$];

    // Values seen at the most recent checked cycle.
    logic       s_r0, s_r1, s_fs;
    logic [3:0] s_nib;

    function automatic void model_reset();
        m_slot = 0;
        m_nib  = IDLE_NIB;
        m_busy = 1'b0;
        m_fs   = 1'b0;
        m_last = 1'b1;
        m_q.delete();
    endfunction

    // Check one cycle at the falling edge, then advance the model across the
    // following rising edge. Returns at posedge + 1.
    task automatic cyc_model();
        logic e0, e1;
        logic [7:0] d;
        @(negedge clk);
        e0 = 1'b0;
        e1 = 1'b0;
        if (m_slot == 3 && m_q.size() == 0 && en) begin
            if (req0_valid && req1_valid) begin
                if (m_last) e0 = 1'b1; else e1 = 1'b1;
            end else if (req0_valid) begin
                e0 = 1'b1;
            end else if (req1_valid) begin
                e1 = 1'b1;
            end
        end
        check("slot", 8'(slot), 8'(m_slot));
        check("nib", 8'(nib), 8'(m_nib));
        check("busy", 8'(busy), 8'(m_busy));
        check("frame_start", 8'(frame_start), 8'(m_fs));
        check("req0_ready", 8'(req0_ready), 8'(e0));
        check("req1_ready", 8'(req1_ready), 8'(e1));
        s_r0  = req0_ready;
        s_r1  = req1_ready;
        s_fs  = frame_start;
        s_nib = nib;
        d = e1 ? req1_data : req0_data;
        @(posedge clk);
        if (e0 || e1) begin
            m_q.push_back({HDR_TAG, e1});
            m_q.push_back(d[3:0]);
            m_q.push_back(d[7:4]);
            m_last = e1;
        end
        if (m_slot == 3) begin
            m_fs = e0 || e1;
            if (m_q.size() != 0) begin
                m_nib  = m_q.pop_front();
                m_busy = 1'b1;
            end else begin
                m_nib  = IDLE_NIB;
                m_busy = 1'b0;
            end
        end else begin
            m_fs = 1'b0;
        end
        m_slot = (m_slot + 1) % 4;
        #1;
    endtask

    // Reset pulse placed between clock edges; leaves slot 0 for the next
    // falling edge.
    task automatic do_reset();
        @(posedge clk);
        #1;
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
    endtask

    task automatic clear_inputs();
        en         = 1'b1;
        req0_valid = 1'b0;
        req0_data  = 8'h00;
        req1_valid = 1'b0;
        req1_data  = 8'h00;
    endtask

    // ---------------------------------------------------------------------
    // Table of single-frame vectors applied from reset.
    // ---------------------------------------------------------------------
    typedef struct {
        logic       en;
        logic       v0;
        logic [7:0] d0;
        logic       v1;
        logic [7:0] d1;
        logic       r0;
        logic       r1;
        logic [3:0] n_hdr;
        logic [3:0] n_lo;
        logic [3:0] n_hi;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int k;
        logic [3:0] exp_nib;
        logic       g;

        rst = 1'b1;
        clear_inputs();
        s_r0 = 1'b0; s_r1 = 1'b0; s_fs = 1'b0; s_nib = 4'h0;
        model_reset();

        tbl[0] = '{1'b1, 1'b1, 8'h5A, 1'b0, 8'h00, 1'b1, 1'b0, 4'hC, 4'hA, 4'h5};
        tbl[1] = '{1'b1, 1'b0, 8'h00, 1'b1, 8'h3C, 1'b0, 1'b1, 4'hD, 4'hC, 4'h3};
        tbl[2] = '{1'b1, 1'b1, 8'h11, 1'b1, 8'h22, 1'b1, 1'b0, 4'hC, 4'h1, 4'h1};
        tbl[3] = '{1'b0, 1'b1, 8'h77, 1'b1, 8'h88, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
        tbl[4] = '{1'b1, 1'b0, 8'h99, 1'b0, 8'h66, 1'b0, 1'b0, 4'h0, 4'h0, 4'h0};
        tbl[5] = '{1'b1, 1'b1, 8'hF0, 1'b0, 8'h00, 1'b1, 1'b0, 4'hC, 4'h0, 4'hF};

        // Reset state (checked while rst is held).
        #3;
        check("rst_nib", 8'(nib), 8'(IDLE_NIB));
        check("rst_slot", 8'(slot), 8'h0);
        check("rst_busy", 8'(busy), 8'h0);
        check("rst_fs", 8'(frame_start), 8'h0);
        check("rst_ready", 8'({req1_ready, req0_ready}), 8'h0);

        for (int i = 0; i < 6; i++) begin
            clear_inputs();
            do_reset();
            en         = tbl[i].en;
            req0_valid = tbl[i].v0;
            req0_data  = tbl[i].d0;
            req1_valid = tbl[i].v1;
            req1_data  = tbl[i].d1;
            repeat (4) @(negedge clk);
            check("tbl_grant_slot", 8'(slot), 8'h3);
            check("tbl_r0", 8'(req0_ready), 8'(tbl[i].r0));
            check("tbl_r1", 8'(req1_ready), 8'(tbl[i].r1));
            @(posedge clk);
            #1;
            req0_valid = 1'b0;
            req1_valid = 1'b0;
            g = tbl[i].r0 | tbl[i].r1;
            for (int p = 0; p < 4; p++) begin
                case (p)
                    0:       exp_nib = tbl[i].n_hdr;
                    1:       exp_nib = tbl[i].n_lo;
                    2:       exp_nib = tbl[i].n_hi;
                    default: exp_nib = IDLE_NIB;
                endcase
                for (int s = 0; s < 4; s++) begin
                    @(negedge clk);
                    check("tbl_nib", 8'(nib), 8'(exp_nib));
                    check("tbl_busy", 8'(busy), 8'(g && (p < 3)));
                    check("tbl_fs", 8'(frame_start), 8'(g && p == 0 && s == 0));
                end
            end
        end

        // Reset then idle: no valid, stream stays idle.
        clear_inputs();
        do_reset();
        repeat (12) cyc_model();

        // Tie / fairness: both valid continuously, headers alternate C, D.
        clear_inputs();
        do_reset();
        req0_valid = 1'b1; req0_data = 8'h11;
        req1_valid = 1'b1; req1_data = 8'h22;
        k = 0;
        repeat (52) begin
            cyc_model();
            check("tie_one_ready", 8'(s_r0 & s_r1), 8'h0);
            if (s_fs) begin
                check("tie_hdr", 8'(s_nib), (k % 2 == 0) ? 8'h0C : 8'h0D);
                k++;
            end
        end
        check("tie_frames", 8'(k), 8'd4);

        // en gating: no grant while en=0; drop en mid-frame of 8'h3C.
        clear_inputs();
        do_reset();
        en = 1'b0;
        req1_valid = 1'b1; req1_data = 8'h3C;
        repeat (8) cyc_model();
        check("en0_nib", 8'(nib), 8'(IDLE_NIB));
        en = 1'b1;
        k = 0;
        for (int i = 0; i < 40; i++) begin
            cyc_model();
            if (s_fs) k++;
            if (s_r1) req1_data = 8'h77;   // next byte stays offered
            if (k == 1 && slot == 2'd2 && i < 12) en = 1'b0;
        end
        check("en_drop_frames", 8'(k), 8'd1);
        check("en_drop_busy", 8'(busy), 8'h0);

        // Reset mid-frame, during the LO period.
        clear_inputs();
        do_reset();
        req0_valid = 1'b1; req0_data = 8'hA5;
        for (int i = 0; i < 10; i++) begin
            cyc_model();
            if (s_r0) req0_valid = 1'b0;
        end
        check("pre_rst_nib", 8'(nib), 8'h05);
        #1;
        rst = 1'b1;
        #1;
        check("mid_rst_nib", 8'(nib), 8'(IDLE_NIB));
        check("mid_rst_slot", 8'(slot), 8'h0);
        check("mid_rst_busy", 8'(busy), 8'h0);
        rst = 1'b0;
        model_reset();
        req1_valid = 1'b1; req1_data = 8'h4B;
        k = 0;
        for (int i = 0; i < 20; i++) begin
            cyc_model();
            if (s_r1) req1_valid = 1'b0;
            if (s_fs) begin
                check("post_rst_hdr", 8'(s_nib), 8'h0D);
                k++;
            end
        end
        check("post_rst_frames", 8'(k), 8'd1);

        // Valid withdrawn before the boundary.
        clear_inputs();
        do_reset();
        req0_valid = 1'b1; req0_data = 8'hE7;
        repeat (2) cyc_model();
        req0_valid = 1'b0;
        repeat (10) cyc_model();
        check("withdraw_busy", 8'(busy), 8'h0);

        // Randomized traffic against the model.
        clear_inputs();
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            cyc_model();
            if (s_r0) begin
                req0_valid = 1'($urandom_range(0, 1));
                req0_data  = 8'($urandom);
            end else if (!req0_valid) begin
                if ($urandom_range(0, 3) == 0) begin
                    req0_valid = 1'b1;
                    req0_data  = 8'($urandom);
                end
            end else if ($urandom_range(0, 31) == 0) begin
                req0_valid = 1'b0;
            end
            if (s_r1) begin
                req1_valid = 1'($urandom_range(0, 1));
                req1_data  = 8'($urandom);
            end else if (!req1_valid) begin
                if ($urandom_range(0, 3) == 0) begin
                    req1_valid = 1'b1;
                    req1_data  = 8'($urandom);
                end
            end else if ($urandom_range(0, 31) == 0) begin
                req1_valid = 1'b0;
            end
            if ($urandom_range(0, 15) == 0) en = ~en;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
